// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a 64-bit on-chip SRAM with independent write (AW/W/B) and read (AR/R) engines.
// Optional build macro AXI_SLV_RANGE_CHK_EN: out-of-window beats are dropped/zeroed and answered with SLVERR.
module axi4_sram_slave #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [7:0]  awlen_i,
    input  logic [1:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    input  logic [3:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [7:0]  arlen_i,
    input  logic [1:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [3:0]  rid_o,
    output logic [63:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i
);
    localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

    logic [63:0] mem_q [DEPTH];

    wstate_e     wstate_q;
    logic        awready_q, wready_q, bvalid_q, werr_q, wfixed_q;
    logic [3:0]  bid_q, wid_q;
    logic [1:0]  bresp_q;
    logic [31:0] waddr_q;
    logic [7:0]  wlen_q, wcnt_q;

    rstate_e     rstate_q;
    logic        arready_q, rvalid_q, rlast_q, rfixed_q;
    logic [3:0]  rid_q;
    logic [1:0]  rresp_q;
    logic [63:0] rdata_q;
    logic [31:0] raddr_q;
    logic [7:0]  rlen_q, rcnt_q;

    logic [31:0]           woff_c, roff_c;
    logic [DEPTH_LOG2-1:0] widx_c, ridx_c;
    logic                  w_inrng_c, r_inrng_c, w_hs_c, w_end_c, w_ok_c;
    logic                  unused_ok_c;

    // Byte offset into the SRAM window; word index is taken from it so addresses alias modulo depth.
    assign woff_c = waddr_q - BASE_ADDR;
    assign roff_c = raddr_q - BASE_ADDR;
    assign widx_c = woff_c[DEPTH_LOG2+2:3];
    assign ridx_c = roff_c[DEPTH_LOG2+2:3];

`ifdef AXI_SLV_RANGE_CHK_EN
    localparam logic [32:0] SPAN = 33'(64'(8) << DEPTH_LOG2);
    assign w_inrng_c = ({1'b0, woff_c} < SPAN);
    assign r_inrng_c = ({1'b0, roff_c} < SPAN);
`else
    assign w_inrng_c = 1'b1;
    assign r_inrng_c = 1'b1;
`endif

    assign unused_ok_c = ^{awsize_i, arsize_i, woff_c, roff_c};

    assign w_hs_c  = (wstate_q == W_DATA) & wvalid_i & wready_q;
    assign w_end_c = wlast_i | (wcnt_q == wlen_q);
    assign w_ok_c  = wlast_i & (wcnt_q == wlen_q) & ~werr_q & w_inrng_c;

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bid_o     = bid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;

    // SRAM write port: byte-enabled, contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_hs_c && w_inrng_c) begin
            for (int k = 0; k < 8; k++) begin
                if (wstrb_i[k]) mem_q[widx_c][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    // Write engine: AW accept, data beats, single B response.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wfixed_q  <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awvalid_i && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wid_q     <= awid_i;
                        waddr_q   <= awaddr_i;
                        wlen_q    <= awlen_i;
                        wfixed_q  <= (awburst_i == BURST_FIXED);
                        wcnt_q    <= '0;
                        werr_q    <= 1'b0;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_c) begin
                        wcnt_q  <= wcnt_q + 8'd1;
                        waddr_q <= wfixed_q ? waddr_q : waddr_q + 32'd8;
                        werr_q  <= werr_q | ~w_inrng_c;
                        if (w_end_c) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= wid_q;
                            bresp_q  <= w_ok_c ? RESP_OKAY : RESP_SLVERR;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Read engine: one SRAM fetch cycle per beat, then hold the beat until accepted.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rfixed_q  <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arvalid_i && arready_q) begin
                        arready_q <= 1'b0;
                        rid_q     <= arid_i;
                        raddr_q   <= araddr_i;
                        rlen_q    <= arlen_i;
                        rfixed_q  <= (arburst_i == BURST_FIXED);
                        rcnt_q    <= '0;
                        rstate_q  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdata_q  <= r_inrng_c ? mem_q[ridx_c] : 64'h0;
                    rresp_q  <= r_inrng_c ? RESP_OKAY : RESP_SLVERR;
                    rlast_q  <= (rcnt_q == rlen_q);
                    rvalid_q <= 1'b1;
                    rstate_q <= R_DATA;
                end
                R_DATA: begin
                    if (rready_i) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            rstate_q <= R_IDLE;
                        end else begin
                            rcnt_q   <= rcnt_q + 8'd1;
                            raddr_q  <= rfixed_q ? raddr_q : raddr_q + 32'd8;
                            rstate_q <= R_FETCH;
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave (16-word SRAM at base 0); honours AXI_SLV_RANGE_CHK_EN if defined.
module tb_axi4_sram_slave;
    localparam logic [1:0] INCR = 2'b01;

    logic        clk, resetn;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [1:0]  awsize, awburst, arsize, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    int n_vec = 0;
    int n_err = 0;

    axi4_sram_slave #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
        .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
        .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
        .rready_i(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = 2'd3; awburst = INCR; awvalid = 1'b1;
        while (!awready && n < 64) begin tick(); n++; end
        chk("aw_wait", 64'(n < 64), 64'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
        int n = 0;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        while (!wready && n < 64) begin tick(); n++; end
        chk("w_wait", 64'(n < 64), 64'd1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 64) begin tick(); n++; end
        chk({tag, "_bwait"}, 64'(n < 64), 64'd1);
        chk({tag, "_bid"}, 64'(bid), 64'(id));
        chk({tag, "_bresp"}, 64'(bresp), 64'(resp));
        tick();
        bready = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = 2'd3; arburst = INCR; arvalid = 1'b1;
        while (!arready && n < 64) begin tick(); n++; end
        chk("ar_wait", 64'(n < 64), 64'd1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic r_beat(input string tag, input logic [63:0] d, input logic [1:0] resp,
                          input logic last, input logic [3:0] id);
        int n = 0;
        rready = 1'b1;
        while (!rvalid && n < 64) begin tick(); n++; end
        chk({tag, "_rwait"}, 64'(n < 64), 64'd1);
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rresp"}, 64'(rresp), 64'(resp));
        chk({tag, "_rlast"}, 64'(rlast), 64'(last));
        chk({tag, "_rid"}, 64'(rid), 64'(id));
        tick();
        rready = 1'b0;
    endtask

    initial begin
        int beat, cyc, n;
        resetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset values, then ready asserts one cycle after release
        repeat (3) tick();
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        resetn = 1'b1;
        #1;
        chk("rel_arready0", 64'(arready), 64'd0);
        tick();
        chk("rel_arready1", 64'(arready), 64'd1);
        chk("rel_awready1", 64'(awready), 64'd1);

        // 1: four-beat write and read-back
        aw_send(4'h3, 32'h40, 8'd3);
        w_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        w_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
        w_beat(64'h3333_3333_3333_3333, 8'hFF, 1'b0);
        w_beat(64'h4444_4444_4444_4444, 8'hFF, 1'b1);
        b_recv("t1", 4'h3, 2'b00);
        ar_send(4'h5, 32'h40, 8'd3);
        r_beat("t1b0", 64'h1111_1111_1111_1111, 2'b00, 1'b0, 4'h5);
        r_beat("t1b1", 64'h2222_2222_2222_2222, 2'b00, 1'b0, 4'h5);
        r_beat("t1b2", 64'h3333_3333_3333_3333, 2'b00, 1'b0, 4'h5);
        r_beat("t1b3", 64'h4444_4444_4444_4444, 2'b00, 1'b1, 4'h5);

        // 2: partial byte strobes
        aw_send(4'h1, 32'h20, 8'd0);
        w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        b_recv("t2a", 4'h1, 2'b00);
        aw_send(4'h1, 32'h20, 8'd0);
        w_beat(64'h0, 8'h0F, 1'b1);
        b_recv("t2b", 4'h1, 2'b00);
        ar_send(4'h1, 32'h20, 8'd0);
        r_beat("t2r", 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'h1);

        // 3: B held under back-pressure, then stalled 8-beat read
        aw_send(4'hA, 32'h0, 8'd7);
        for (int i = 0; i < 8; i++) w_beat(64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, i == 7);
        for (int i = 0; i < 5; i++) begin
            chk("t3_bvalid_held", 64'(bvalid), 64'd1);
            chk("t3_awready_low", 64'(awready), 64'd0);
            tick();
        end
        b_recv("t3", 4'hA, 2'b00);
        ar_send(4'h2, 32'h0, 8'd7);
        beat = 0;
        cyc = 0;
        while (beat < 8 && cyc < 100) begin
            rready = (cyc % 3 == 0);
            if (rvalid) begin
                chk("t3_rdata", rdata, 64'hC0DE_0000_0000_0000 + 64'(beat));
                if (rready) begin
                    chk("t3_rlast", 64'(rlast), 64'(beat == 7));
                    beat++;
                end
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        chk("t3_beats", 64'(beat), 64'd8);

        // 4: early wlast -> SLVERR, only two words written
        aw_send(4'h6, 32'h0, 8'd3);
        w_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
        w_beat(64'hDEAD_BEEF_0000_0002, 8'hFF, 1'b1);
        chk("t4_bvalid_next", 64'(bvalid), 64'd1);
        chk("t4_wready_off", 64'(wready), 64'd0);
        b_recv("t4", 4'h6, 2'b10);
        ar_send(4'h6, 32'h0, 8'd3);
        r_beat("t4b0", 64'hDEAD_BEEF_0000_0001, 2'b00, 1'b0, 4'h6);
        r_beat("t4b1", 64'hDEAD_BEEF_0000_0002, 2'b00, 1'b0, 4'h6);
        r_beat("t4b2", 64'hC0DE_0000_0000_0002, 2'b00, 1'b0, 4'h6);
        r_beat("t4b3", 64'hC0DE_0000_0000_0003, 2'b00, 1'b1, 4'h6);
        aw_send(4'h7, 32'h10, 8'd0);
        w_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        b_recv("t4n", 4'h7, 2'b00);

        // 5: burst crossing the top of the SRAM window
        aw_send(4'h9, 32'h78, 8'd1);
        w_beat(64'h5555_5555_5555_5555, 8'hFF, 1'b0);
        w_beat(64'h6666_6666_6666_6666, 8'hFF, 1'b1);
`ifdef AXI_SLV_RANGE_CHK_EN
        b_recv("t5", 4'h9, 2'b10);
        ar_send(4'h9, 32'h78, 8'd1);
        r_beat("t5b0", 64'h5555_5555_5555_5555, 2'b00, 1'b0, 4'h9);
        r_beat("t5b1", 64'h0, 2'b10, 1'b1, 4'h9);
        ar_send(4'h9, 32'h0, 8'd0);
        r_beat("t5i0", 64'hDEAD_BEEF_0000_0001, 2'b00, 1'b1, 4'h9);
`else
        b_recv("t5", 4'h9, 2'b00);
        ar_send(4'h9, 32'h78, 8'd1);
        r_beat("t5b0", 64'h5555_5555_5555_5555, 2'b00, 1'b0, 4'h9);
        r_beat("t5b1", 64'h6666_6666_6666_6666, 2'b00, 1'b1, 4'h9);
        ar_send(4'h9, 32'h0, 8'd0);
        r_beat("t5i0", 64'h6666_6666_6666_6666, 2'b00, 1'b1, 4'h9);
`endif

        // 6: reset in the middle of an 8-beat read
        ar_send(4'hC, 32'h40, 8'd7);
        r_beat("t6b0", 64'h1111_1111_1111_1111, 2'b00, 1'b0, 4'hC);
        n = 0;
        while (!rvalid && n < 64) begin tick(); n++; end
        chk("t6_rwait", 64'(n < 64), 64'd1);
        resetn = 1'b0;
        #1;
        chk("t6_rvalid", 64'(rvalid), 64'd0);
        chk("t6_rdata", rdata, 64'h0);
        chk("t6_arready", 64'(arready), 64'd0);
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("t6_arready_rel", 64'(arready), 64'd0);
        tick();
        chk("t6_arready_up", 64'(arready), 64'd1);
        chk("t6_rvalid_idle", 64'(rvalid), 64'd0);
        ar_send(4'hD, 32'h48, 8'd0);
        r_beat("t6k0", 64'h2222_2222_2222_2222, 2'b00, 1'b1, 4'hD);
        ar_send(4'hD, 32'h10, 8'd0);
        r_beat("t6k1", 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1, 4'hD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
